// File: rtl/rv32_pkg.sv
// Shared types and constants for the instruction fetch front end.
package rv32_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StFlush,
    StValid
  } fetch_state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/redirect_sel.sv
// Combines branch and jump requests into one redirect with a word-aligned target.
module redirect_sel #(
  parameter int unsigned XLEN = 32
) (
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            br_en_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    redirect_o   = jump_i | (br_en_i & br_taken_i);
    // Jump has priority over a simultaneously resolving branch.
    raw_target   = jump_i ? jump_target_i : br_target_i;
    target_o     = {raw_target[XLEN-1:2], 2'b00};
    misaligned_o = redirect_o & (|raw_target[1:0]);
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter owner and fetch sequencer between instruction memory and decode.
module pc_fetch_ctrl
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            br_en_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] inst_out_o,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] pc_out_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            misalign_err_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] pending_q, pending_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic [XLEN-1:0] flush_target;

  redirect_sel #(
    .XLEN(XLEN)
  ) u_redirect_sel (
    .jump_i       (jump_i),
    .jump_target_i(jump_target_i),
    .br_en_i      (br_en_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .redirect_o   (redirect),
    .target_o     (target),
    .misaligned_o (misaligned)
  );

  // A redirect in the same cycle the flushed fetch completes supersedes the pending one.
  assign flush_target = redirect ? target : pending_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    pc_out_d   = pc_out_q;
    pending_d  = pending_q;
    misalign_d = (state_q != StBoot) && misaligned;

    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end

      StFetch: begin
        if (imem_ready_i) begin
          if (redirect) begin
            pc_d   = target;
            addr_d = target;
          end else begin
            inst_d   = imem_rdata_i;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            req_d    = 1'b0;
            state_d  = StValid;
          end
        end else if (redirect) begin
          pending_d = target;
          state_d   = StFlush;
        end
      end

      StFlush: begin
        if (redirect) begin
          pending_d = target;
        end
        if (imem_ready_i) begin
          pc_d    = flush_target;
          addr_d  = flush_target;
          state_d = StFetch;
        end
      end

      StValid: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = target;
          addr_d  = target;
          req_d   = 1'b1;
          state_d = StFetch;
        end else if (!stall_i) begin
          valid_d = 1'b0;
          pc_d    = pc_q + XLEN'(PC_STEP);
          addr_d  = pc_q + XLEN'(PC_STEP);
          req_d   = 1'b1;
          state_d = StFetch;
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      inst_q     <= RV_NOP;
      valid_q    <= 1'b0;
      pc_out_q   <= RESET_PC;
      misalign_q <= 1'b0;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      pc_out_q   <= pc_out_d;
      misalign_q <= misalign_d;
      pending_q  <= pending_d;
    end
  end

  assign imem_req_o     = req_q;
  assign imem_addr_o    = addr_q;
  assign inst_out_o     = inst_q;
  assign inst_valid_o   = valid_q;
  assign pc_out_o       = pc_out_q;
  assign pc_plus4_o     = pc_out_q + XLEN'(PC_STEP);
  assign misalign_err_o = misalign_q;

endmodule
